// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer: FSM states, LFSR seed/taps,
// default saturation value and a BCD increment helper.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GO,
        ST_DONE,
        ST_EARLY
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          MAX_MS_DEFAULT = 9999;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reaction_timer_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse; an input already high
// when reset is released must go low once before it can produce a pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_pulse
);

    logic       r_s1;
    logic       r_s2;
    logic       r_prev;
    logic       r_armed;
    logic       r_pulse;
    logic [1:0] r_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
            r_fill  <= 2'b00;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_fill <= {r_fill[0], 1'b1};
            // r_s2 only reflects the real input once both sync stages have refilled
            if (r_fill[1] && !r_s2) begin
                r_armed <= 1'b1;
            end
            r_pulse <= r_s2 & ~r_prev & r_armed;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random delay, lamp on, count 1 ms ticks until the reaction press.
// Optional BCD result counter enabled by defining REACTION_TIMER_BCD_EN.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int DELAY_MIN       = 1000,
    parameter int DELAY_SPAN_BITS = 10,
    parameter int MAX_MS          = MAX_MS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        slowclk,
    input  logic        start,
    input  logic        react,
    output logic        led,
    output logic [13:0] time_ms,
    output logic        done,
    output logic        early,
    output logic [15:0] time_bcd
);

    localparam int          DLY_W = $clog2(DELAY_MIN + (1 << DELAY_SPAN_BITS));
    localparam logic [13:0] MAX_T = 14'(MAX_MS);

    logic             w_tick;
    logic             w_start_p;
    logic             w_react_p;
    logic [15:0]      r_lfsr;
    state_t           r_state;
    state_t           w_state_nx;
    logic [DLY_W-1:0] r_delay;
    logic [DLY_W-1:0] w_delay_nx;
    logic [DLY_W-1:0] w_delay_load;
    logic [13:0]      r_time;
    logic [13:0]      w_time_nx;
    logic             r_led;
    logic             w_led_nx;
    logic             r_done;
    logic             w_done_nx;
    logic             r_early;
    logic             w_early_nx;

    edge_sync u_sync_tick  (.clk(clk), .rst(rst), .i_raw(slowclk), .o_pulse(w_tick));
    edge_sync u_sync_start (.clk(clk), .rst(rst), .i_raw(start),   .o_pulse(w_start_p));
    edge_sync u_sync_react (.clk(clk), .rst(rst), .i_raw(react),   .o_pulse(w_react_p));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign w_delay_load = DLY_W'(DELAY_MIN) + DLY_W'(r_lfsr[DELAY_SPAN_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_delay <= '0;
            r_time  <= '0;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
            r_early <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_delay <= w_delay_nx;
            r_time  <= w_time_nx;
            r_led   <= w_led_nx;
            r_done  <= w_done_nx;
            r_early <= w_early_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_delay_nx = r_delay;
        w_time_nx  = r_time;
        w_led_nx   = r_led;
        w_done_nx  = r_done;
        w_early_nx = r_early;
        case (r_state)
            ST_IDLE, ST_DONE, ST_EARLY: begin
                if (w_start_p) begin
                    w_state_nx = ST_WAIT;
                    w_delay_nx = w_delay_load;
                    w_time_nx  = '0;
                    w_led_nx   = 1'b0;
                    w_done_nx  = 1'b0;
                    w_early_nx = 1'b0;
                end
            end
            ST_WAIT: begin
                // A false start beats a lamp-on in the same cycle
                if (w_react_p) begin
                    w_state_nx = ST_EARLY;
                    w_early_nx = 1'b1;
                end else if (w_tick) begin
                    w_delay_nx = r_delay - 1'b1;
                    if (r_delay == DLY_W'(1)) begin
                        w_state_nx = ST_GO;
                        w_led_nx   = 1'b1;
                        w_time_nx  = '0;
                    end
                end
            end
            ST_GO: begin
                if (w_react_p) begin
                    w_state_nx = ST_DONE;
                    w_led_nx   = 1'b0;
                    w_done_nx  = 1'b1;
                end else if (w_tick) begin
                    if (r_time == MAX_T) begin
                        w_state_nx = ST_DONE;
                        w_led_nx   = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_time_nx = r_time + 14'd1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

`ifdef REACTION_TIMER_BCD_EN
    logic [15:0] r_bcd;

    // time_ms only ever clears to zero or steps by one, so follow those two moves
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd <= '0;
        end else if (w_time_nx == '0) begin
            r_bcd <= '0;
        end else if (w_time_nx != r_time) begin
            r_bcd <= bcd_inc(r_bcd);
        end
    end

    assign time_bcd = r_bcd;
`else
    assign time_bcd = 16'd0;
`endif

    assign led     = r_led;
    assign time_ms = r_time;
    assign done    = r_done;
    assign early   = r_early;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: two instances (long and short saturation) share the
// stimulus; expectations come from an event-timeline model of each round.
module tb_reaction_timer;

    localparam int DMIN  = 4;
    localparam int MAXA  = 9999;
    localparam int MAXB  = 12;
    localparam int NEVER = 32'h3fff_0000;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        slowclk = 1'b0;
    logic        start   = 1'b0;
    logic        react   = 1'b0;
    logic        led_a, done_a, early_a;
    logic [13:0] time_a;
    logic [15:0] bcd_a;
    logic        led_b, done_b, early_b;
    logic [13:0] time_b;
    logic [15:0] bcd_b;

    reaction_timer #(.DELAY_MIN(DMIN), .DELAY_SPAN_BITS(2), .MAX_MS(MAXA)) dut_a (
        .clk(clk), .rst(rst), .slowclk(slowclk), .start(start), .react(react),
        .led(led_a), .time_ms(time_a), .done(done_a), .early(early_a), .time_bcd(bcd_a)
    );

    reaction_timer #(.DELAY_MIN(DMIN), .DELAY_SPAN_BITS(2), .MAX_MS(MAXB)) dut_b (
        .clk(clk), .rst(rst), .slowclk(slowclk), .start(start), .react(react),
        .led(led_b), .time_ms(time_b), .done(done_b), .early(early_b), .time_bcd(bcd_b)
    );

    always #5 clk = ~clk;

    int          ec = 0;
    int          rno = 0;
    logic [15:0] lfsr_m = 16'h0000;
    int          s_on = -1, s_off = -1, s2_on = -1, s2_off = -1;
    int          r_on = -1, r_off = -1, r2_on = -1, r2_off = -1;
    int          n_tests = 0;
    int          n_fail = 0;
    int          p_time[2];
    bit          p_done[2];
    bit          p_early[2];
    int          g_L, g_G, g_R;
    bit          g_early;
    int          g_dn[2];

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Expected outputs after edge e of the current round for instance i
    function automatic int exp_time(input int i, input int e);
        if (e < g_L) return p_time[i];
        if (g_early || e < g_G) return 0;
        return imin((e - g_G) / 8, (g_dn[i] - 1 - g_G) / 8);
    endfunction

    function automatic bit exp_led(input int i, input int e);
        return (e >= g_L) && !g_early && (e >= g_G) && (e < g_dn[i]);
    endfunction

    function automatic bit exp_done(input int i, input int e);
        if (e < g_L) return p_done[i];
        return !g_early && (e >= g_dn[i]);
    endfunction

    function automatic bit exp_early(input int i, input int e);
        if (e < g_L) return p_early[i];
        return g_early && (e >= g_R);
    endfunction

    task automatic apply_inputs();
        slowclk = ((ec % 8) < 4);
        start   = (ec >= s_on && ec < s_off) || (ec >= s2_on && ec < s2_off);
        react   = (ec >= r_on && ec < r_off) || (ec >= r2_on && ec < r2_off);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) lfsr_m = 16'hACE1;
        else     lfsr_m = lfsr_step(lfsr_m);
        ec++;
        #1;
        apply_inputs();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, expv, ec);
        end
    endtask

    task automatic check_exp(input int i, input string tag, input bit e_led, input int e_time,
                             input bit e_done, input bit e_early);
        logic [31:0] o_led, o_time, o_done, o_early, o_bcd, e_bcd;
        if (i == 0) begin
            o_led = 32'(led_a); o_time = 32'(time_a); o_done = 32'(done_a);
            o_early = 32'(early_a); o_bcd = 32'(bcd_a);
        end else begin
            o_led = 32'(led_b); o_time = 32'(time_b); o_done = 32'(done_b);
            o_early = 32'(early_b); o_bcd = 32'(bcd_b);
        end
`ifdef REACTION_TIMER_BCD_EN
        e_bcd = 32'(to_bcd(e_time));
`else
        e_bcd = 32'd0;
`endif
        chk({tag, "_led"},   o_led,   32'(e_led));
        chk({tag, "_time"},  o_time,  32'(e_time));
        chk({tag, "_done"},  o_done,  32'(e_done));
        chk({tag, "_early"}, o_early, 32'(e_early));
        chk({tag, "_bcd"},   o_bcd,   e_bcd);
    endtask

    task automatic check_round();
        for (int i = 0; i < 2; i++) begin
            check_exp(i, $sformatf("r%0d%s", rno, (i == 0) ? "a" : "b"),
                      exp_led(i, ec), exp_time(i, ec), exp_done(i, ec), exp_early(i, ec));
        end
    endtask

    task automatic check_zero(input string tag);
        check_exp(0, {tag, "a"}, 1'b0, 0, 1'b0, 1'b0);
        check_exp(1, {tag, "b"}, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // mode 0: react n ticks into GO; 1: react aligned with tick n+1; 2: false start;
    // 3: no react, reset asserted in GO
    task automatic round(input int mode, input int n);
        int c, d_exp, t1, tD, r, fin, stop_e;
        rno++;
        c     = ec;
        g_L   = c + 4;
        s_on  = c;
        s_off = c + int'($urandom_range(10, 5));
        apply_inputs();
        repeat (3) begin
            step();
            check_round();
        end
        d_exp = DMIN + int'(lfsr_m[1:0]);
        t1    = (c / 8 + 1) * 8;
        tD    = t1 + 8 * (d_exp - 1);
        g_G   = tD + 4;
        case (mode)
            0:       r = tD + 8 * n + int'($urandom_range(7, 1));
            1:       r = tD + 8 * (n + 1);
            2:       r = int'($urandom_range(tD, c + 4));
            default: r = NEVER;
        endcase
        if (mode == 3) begin
            g_R = NEVER;
        end else begin
            g_R   = r + 4;
            r_on  = r;
            r_off = r + int'($urandom_range(10, 5));
        end
        g_early = (g_R <= g_G);
        g_dn[0] = g_early ? g_R : imin(g_R, g_G + 8 * (MAXA + 1));
        g_dn[1] = g_early ? g_R : imin(g_R, g_G + 8 * (MAXB + 1));
        fin     = (g_dn[0] > g_dn[1]) ? g_dn[0] : g_dn[1];
        if (mode <= 1 && n >= 4) begin
            s2_on  = g_G + 10;
            s2_off = g_G + 15;
        end
        if (mode == 3) begin
            stop_e = g_G + 20;
        end else begin
            r2_on  = fin + 12;
            r2_off = fin + 18;
            stop_e = fin + 30;
        end
        while (ec < stop_e) begin
            step();
            check_round();
        end
        if (mode == 3) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            check_zero($sformatf("abort%0d", rno));
            repeat (20) begin
                step();
                check_zero($sformatf("post_abort%0d", rno));
            end
            for (int i = 0; i < 2; i++) begin
                p_time[i] = 0; p_done[i] = 1'b0; p_early[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                p_time[i]  = exp_time(i, ec);
                p_done[i]  = exp_done(i, ec);
                p_early[i] = exp_early(i, ec);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            p_time[i] = 0; p_done[i] = 1'b0; p_early[i] = 1'b0;
        end
        g_L = NEVER; g_G = NEVER; g_R = NEVER; g_early = 1'b0;
        g_dn[0] = NEVER; g_dn[1] = NEVER;
        apply_inputs();
        rst = 1'b1;
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        repeat (16) step();

        round(0, 25);
        round(2, 0);
        round(1, 7);
        round(0, int'($urandom_range(20, 3)));
        round(3, 0);

        // Start held through reset release must not start a round
        s_on  = ec;
        s_off = ec + 1000;
        rst   = 1'b1;
        apply_inputs();
        repeat (3) step();
        rst = 1'b0;
        repeat (80) begin
            step();
            check_zero("held");
        end
        s_off = ec;
        apply_inputs();
        repeat (16) step();

        round(0, int'($urandom_range(15, 4)));
        round(2, 0);
        for (int k = 0; k < 3; k++) begin
            round(int'($urandom_range(2, 0)), int'($urandom_range(20, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
